// File: rtl/trackball_quad_encoder.sv
`default_nettype none
// ============================================================================
// Module   : trackball_quad_encoder
// Brief    : Turns host mouse packets (signed dx/dy plus a packet toggle) into
//            rate-limited Gray-code quadrature phase pairs for two decoder axes.
// Revision : 1.0  initial release
// ============================================================================
module trackball_quad_encoder #(
    parameter int STEP_DIV = 1024,
    parameter int ACC_W    = 12,
    parameter int SHIFT    = 0,
    parameter int INV_X    = 0,
    parameter int INV_Y    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mouse_toggle,
    input  logic signed [8:0] dx,
    input  logic signed [8:0] dy,
    output logic              h_a,
    output logic              h_b,
    output logic              v_a,
    output logic              v_b,
    output logic              busy
);

    localparam int c_cnt_w = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int c_del_w = 10 + SHIFT;
    // Headroom for acc + shifted delta - step before saturating.
    localparam int c_sum_w = ((ACC_W > c_del_w) ? ACC_W : c_del_w) + 2;
    localparam logic signed [c_sum_w-1:0] c_acc_max = c_sum_w'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [c_sum_w-1:0] c_acc_min = -c_acc_max;
    localparam logic signed [c_sum_w-1:0] c_one     = c_sum_w'(1);

    logic [c_cnt_w-1:0]      r_count;
    logic                    r_prev_toggle;
    logic                    r_armed;
    logic signed [ACC_W-1:0] r_acc_x;
    logic signed [ACC_W-1:0] r_acc_y;
    logic [1:0]              r_h_ph;
    logic [1:0]              r_v_ph;
    logic                    r_busy;

    logic                    w_tick;
    logic                    w_packet;
    logic signed [ACC_W-1:0] w_acc_x_nxt;
    logic signed [ACC_W-1:0] w_acc_y_nxt;

    function automatic logic signed [ACC_W-1:0] acc_update(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [8:0]       d,
        input logic                    inv,
        input logic                    take,
        input logic                    step
    );
        logic signed [c_sum_w-1:0] delta;
        logic signed [c_sum_w-1:0] sum;
        delta = '0;
        if (take) begin
            delta = c_sum_w'(d);
        end
        if (inv) begin
            delta = -delta;
        end
        delta = delta <<< SHIFT;
        sum   = c_sum_w'(acc) + delta;
        // The step direction comes from the accumulator before this packet lands.
        if (step && (acc > 0)) begin
            sum = sum - c_one;
        end else if (step && (acc < 0)) begin
            sum = sum + c_one;
        end
        if (sum > c_acc_max) begin
            sum = c_acc_max;
        end else if (sum < c_acc_min) begin
            sum = c_acc_min;
        end
        return sum[ACC_W-1:0];
    endfunction

    // {a,b} forward: 00 -> 10 -> 11 -> 01 -> 00; backward is the reverse.
    function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic fwd);
        logic [1:0] nxt;
        nxt = ph;
        case (ph)
            2'b00:   nxt = fwd ? 2'b10 : 2'b01;
            2'b10:   nxt = fwd ? 2'b11 : 2'b00;
            2'b11:   nxt = fwd ? 2'b01 : 2'b10;
            default: nxt = fwd ? 2'b00 : 2'b11;
        endcase
        return nxt;
    endfunction

    assign w_tick      = (r_count == c_cnt_w'(STEP_DIV - 1));
    assign w_packet    = r_armed & (mouse_toggle ^ r_prev_toggle);
    assign w_acc_x_nxt = acc_update(r_acc_x, dx, (INV_X != 0), w_packet, w_tick);
    assign w_acc_y_nxt = acc_update(r_acc_y, dy, (INV_Y != 0), w_packet, w_tick);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count       <= '0;
            r_prev_toggle <= 1'b0;
            r_armed       <= 1'b0;
            r_acc_x       <= '0;
            r_acc_y       <= '0;
            r_h_ph        <= 2'b00;
            r_v_ph        <= 2'b00;
            r_busy        <= 1'b0;
        end else begin
            r_count       <= w_tick ? '0 : r_count + c_cnt_w'(1);
            r_prev_toggle <= mouse_toggle;
            r_armed       <= 1'b1;
            if (enable) begin
                r_acc_x <= w_acc_x_nxt;
                r_acc_y <= w_acc_y_nxt;
                r_busy  <= (w_acc_x_nxt != '0) | (w_acc_y_nxt != '0);
                if (w_tick && (r_acc_x != '0)) begin
                    r_h_ph <= phase_step(r_h_ph, r_acc_x > 0);
                end
                if (w_tick && (r_acc_y != '0)) begin
                    r_v_ph <= phase_step(r_v_ph, r_acc_y > 0);
                end
            end else begin
                r_acc_x <= '0;
                r_acc_y <= '0;
                r_busy  <= 1'b0;
            end
        end
    end

    assign h_a  = r_h_ph[1];
    assign h_b  = r_h_ph[0];
    assign v_a  = r_v_ph[1];
    assign v_b  = r_v_ph[0];
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_trackball_quad_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_trackball_quad_encoder
// Brief    : Randomised scoreboard bench; a position/accumulator model predicts
//            every quadrature edge, a monitor matches DUT edges against it.
// Revision : 1.0  initial release
// ============================================================================
module tb_trackball_quad_encoder;

    localparam int STEP_DIV = 4;
    localparam int ACC_W    = 8;
    localparam int SHIFT    = 0;
    localparam int INV_X    = 0;
    localparam int INV_Y    = 0;
    localparam int LIM      = (1 << (ACC_W - 1)) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              mouse_toggle;
    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic              h_a, h_b, v_a, v_b, busy;

    always #5 clk = ~clk;

    trackball_quad_encoder #(
        .STEP_DIV(STEP_DIV), .ACC_W(ACC_W), .SHIFT(SHIFT), .INV_X(INV_X), .INV_Y(INV_Y)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mouse_toggle(mouse_toggle),
        .dx(dx), .dy(dy), .h_a(h_a), .h_b(h_b), .v_a(v_a), .v_b(v_b), .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: motion is a signed count of pending edges per axis and
    // the emitted position is an unbounded integer mapped onto the Gray cycle.
    typedef struct {
        logic [1:0] ph;
        int         stamp;
    } ev_t;
    ev_t qh[$];
    ev_t qv[$];

    int   m_cnt, m_acc_x, m_acc_y, m_pos_h, m_pos_v, m_sx, m_sy, m_ddx, m_ddy;
    bit   m_armed, m_pkt, m_tick, m_busy;
    logic m_prev;

    function automatic logic [1:0] gray(input int pos);
        int p;
        p = ((pos % 4) + 4) % 4;
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int clamp(input int v);
        return (v > LIM) ? LIM : ((v < -LIM) ? -LIM : v);
    endfunction

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_acc_x = 0; m_acc_y = 0; m_pos_h = 0; m_pos_v = 0;
            m_armed = 0; m_prev = 1'b0; m_busy = 0;
            qh.delete(); qv.delete();
        end else begin
            m_tick  = (m_cnt % STEP_DIV) == (STEP_DIV - 1);
            m_pkt   = m_armed && (mouse_toggle != m_prev);
            m_prev  = mouse_toggle;
            m_armed = 1;
            m_cnt++;
            if (enable) begin
                m_ddx = m_pkt ? int'(dx) * (INV_X != 0 ? -1 : 1) * (1 << SHIFT) : 0;
                m_ddy = m_pkt ? int'(dy) * (INV_Y != 0 ? -1 : 1) * (1 << SHIFT) : 0;
                m_sx  = m_tick ? sgn(m_acc_x) : 0;
                m_sy  = m_tick ? sgn(m_acc_y) : 0;
                if (m_sx != 0) begin
                    m_pos_h += m_sx;
                    qh.push_back('{gray(m_pos_h), m_cnt});
                end
                if (m_sy != 0) begin
                    m_pos_v += m_sy;
                    qv.push_back('{gray(m_pos_v), m_cnt});
                end
                m_acc_x = clamp(m_acc_x + m_ddx - m_sx);
                m_acc_y = clamp(m_acc_y + m_ddy - m_sy);
            end else begin
                m_acc_x = 0;
                m_acc_y = 0;
            end
            m_busy = (m_acc_x != 0) || (m_acc_y != 0);
        end
    end

    // Monitor: every DUT phase change must match the oldest predicted edge.
    logic [1:0] seen_h, seen_v;
    ev_t        ev;
    always @(negedge clk) begin
        if (reset) begin
            seen_h = {h_a, h_b};
            seen_v = {v_a, v_b};
        end else begin
            if ({h_a, h_b} != seen_h) begin
                if (qh.size() == 0) begin
                    chk("h_unexpected_edge", int'({h_a, h_b}), int'(seen_h));
                end else begin
                    ev = qh.pop_front();
                    chk("h_phase", int'({h_a, h_b}), int'(ev.ph));
                    chk("h_edge_cycle", m_cnt, ev.stamp);
                end
                seen_h = {h_a, h_b};
            end else if (qh.size() > 0 && qh[0].stamp < m_cnt) begin
                ev = qh.pop_front();
                chk("h_missing_edge", int'({h_a, h_b}), int'(ev.ph));
            end
            if ({v_a, v_b} != seen_v) begin
                if (qv.size() == 0) begin
                    chk("v_unexpected_edge", int'({v_a, v_b}), int'(seen_v));
                end else begin
                    ev = qv.pop_front();
                    chk("v_phase", int'({v_a, v_b}), int'(ev.ph));
                    chk("v_edge_cycle", m_cnt, ev.stamp);
                end
                seen_v = {v_a, v_b};
            end else if (qv.size() > 0 && qv[0].stamp < m_cnt) begin
                ev = qv.pop_front();
                chk("v_missing_edge", int'({v_a, v_b}), int'(ev.ph));
            end
            chk("busy", int'(busy), int'(m_busy));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int x, input int y);
        @(negedge clk);
        dx = 9'(x);
        dy = 9'(y);
        mouse_toggle = ~mouse_toggle;
    endtask

    int guard;

    initial begin
        reset = 1'b1; enable = 1'b1; mouse_toggle = 1'b0; dx = '0; dy = '0;
        idle(3);
        chk("reset_outputs", int'({h_a, h_b, v_a, v_b, busy}), 0);
        reset = 1'b0;
        idle(2);
        // Single-axis moves, both directions.
        send(3, 0);   idle(20);
        send(0, -2);  idle(20);
        // Saturation: 400 units into a +/-127 accumulator.
        repeat (4) send(100, 0);
        send(0, -200); send(0, -200);
        idle(560);
        // Packets landing at every offset relative to the step tick.
        for (int k = 0; k < 4; k++) begin
            send(2, -2); idle(k); send(5, -5); idle(40);
        end
        // Toggle held high through reset release must not count as a packet.
        @(negedge clk); reset = 1'b1; mouse_toggle = 1'b1;
        idle(2); reset = 1'b0;
        idle(6);
        chk("armed_no_motion", int'({h_a, h_b, busy}), 0);
        send(1, 0); idle(10);
        // Enable drop mid-motion freezes phases and clears motion.
        send(50, -50); idle(10);
        @(negedge clk); enable = 1'b0;
        idle(20);
        chk("disabled_busy", int'(busy), 0);
        enable = 1'b1;
        send(60, -60); idle(30);
        // Asynchronous reset mid-motion.
        @(posedge clk); #2 reset = 1'b1;
        #1 chk("async_reset", int'({h_a, h_b, v_a, v_b, busy}), 0);
        idle(2); reset = 1'b0;
        idle(2);
        // Random traffic: dx/dy change every cycle, only toggled packets count.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            dx = 9'($urandom);
            dy = 9'($urandom);
            if ($urandom_range(0, 7) == 0) mouse_toggle = ~mouse_toggle;
            enable = ($urandom_range(0, 149) != 0);
        end
        @(negedge clk); enable = 1'b1;
        guard = 0;
        while ((m_busy || busy) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", int'(guard < 2000), 1);
        idle(STEP_DIV + 2);
        chk("drain_h_queue", qh.size(), 0);
        chk("drain_v_queue", qv.size(), 0);
        chk("final_h_phase", int'({h_a, h_b}), int'(gray(m_pos_h)));
        chk("final_v_phase", int'({v_a, v_b}), int'(gray(m_pos_v)));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
